lvds_rx_deframer: RTL and testbench

- Downstream of the DDR receive primitive on the LVDS link.
- Consumes the 2-bit-per-clock deserialised stream and finds the 32-bit frame boundary.
- Checks frame sync and extracts 13-bit I/Q samples and the end-of-message marker.
- Provides lock status and an error counter to the capture FIFO and to control (GPIO status).

---
 rtl/lvds_rx_deframer.sv | 146 ++++++++++++++
 tb/tb_lvds_rx_deframer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_deframer.sv
// LVDS receive deframer: aligns the 2-bit-per-clock stream to 32-bit frames, validates sync,
// and extracts I/Q samples and end-of-message markers with lock tracking and an error count.
module lvds_rx_deframer #(
    parameter int unsigned LOCK_COUNT   = 3,
    parameter int unsigned UNLOCK_COUNT = 4,
    parameter int unsigned ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           rx_d,
    input  logic                 rx_en,
    input  logic                 clear_err,
    output logic [12:0]          sample_i,
    output logic [12:0]          sample_q,
    output logic                 sample_valid,
    output logic                 eom,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int unsigned CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] UNLOCK_N = CNT_W'(UNLOCK_COUNT);

    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;

    state_t           state;
    logic [31:0]      sr;
    logic             upd;
    logic [3:0]       phase;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] miss;

    logic             is_sync, is_data, is_eomf, is_idle, good;
    logic             boundary, hunt_hit, lock_done, deliver, lock_bad;
    logic [CNT_W-1:0] match_inc, miss_inc;

    assign is_sync  = (sr[31:30] == 2'b10) && (sr[15:14] == 2'b01) && !sr[0];
    assign is_data  = is_sync && sr[16];
    assign is_eomf  = is_sync && !sr[16] && (sr[29:17] == 13'd0) && (sr[13:1] == 13'd0);
    assign is_idle  = (sr == 32'd0);
    assign good     = is_data || is_eomf;

    assign boundary  = upd && (phase == 4'd0);
    assign match_inc = match_cnt + 1'b1;
    assign miss_inc  = miss + 1'b1;
    assign hunt_hit  = upd && (state == ST_HUNT) && is_data;

    // The frame that completes acquisition is delivered exactly as a locked frame would be.
    assign lock_done = ((state == ST_VERIFY) && boundary && good && (match_inc >= LOCK_N))
                    || (hunt_hit && (LOCK_COUNT <= 1));
    assign deliver   = lock_done || ((state == ST_LOCKED) && boundary);
    assign lock_bad  = (state == ST_LOCKED) && boundary && !good && !is_idle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_HUNT;
            match_cnt <= '0;
            miss      <= '0;
            locked    <= 1'b0;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (hunt_hit) begin
                        match_cnt <= CNT_W'(1);
                        miss      <= '0;
                        if (lock_done) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (boundary) begin
                        if (good) begin
                            match_cnt <= match_inc;
                            if (lock_done) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (!is_idle) begin
                            state <= ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        if (good) begin
                            miss <= '0;
                        end else if (!is_idle) begin
                            miss <= miss_inc;
                            if (miss_inc >= UNLOCK_N) begin
                                state  <= ST_HUNT;
                                locked <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state  <= ST_HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr           <= '0;
            upd          <= 1'b0;
            phase        <= '0;
            err_cnt      <= '0;
            sample_i     <= '0;
            sample_q     <= '0;
            sample_valid <= 1'b0;
            eom          <= 1'b0;
        end else begin
            upd <= rx_en;
            if (rx_en) begin
                sr <= {sr[29:0], rx_d[0], rx_d[1]};
            end

            // A hunt hit defines the frame end, so the next boundary is 16 checks later.
            if (hunt_hit) begin
                phase <= 4'd1;
            end else if (upd) begin
                phase <= phase + 4'd1;
            end

            sample_valid <= deliver && is_data;
            eom          <= deliver && is_eomf;
            if (deliver && is_data) begin
                sample_i <= sr[29:17];
                sample_q <= sr[13:1];
            end

            if (clear_err) begin
                err_cnt <= '0;
            end else if (lock_bad && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Directed bench for lvds_rx_deframer: frame table plus reset and rx_en-gap sequences,
// with a second instance using a 2-bit error counter to expose saturation.
module tb_lvds_rx_deframer;
    logic        clk = 1'b0;
    logic        reset_n, rx_en, clear_err;
    logic [1:0]  rx_d;
    logic [12:0] sample_i, sample_q, sample_i_b, sample_q_b;
    logic        sample_valid, eom, locked, sample_valid_b, eom_b, locked_b;
    logic [7:0]  err_cnt;
    logic [1:0]  err_cnt_b;

    typedef struct {
        logic [31:0] frame;
        logic        clr;
        logic        sv;
        logic        ev;
        logic [12:0] ei;
        logic [12:0] eq;
        logic        lk;
        logic [7:0]  e1;
        logic [1:0]  e2;
    } vec_t;

    vec_t        vecs[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    bit          mon_on = 1'b0;
    logic [12:0] mon_i[$];
    logic [12:0] mon_q[$];

    localparam logic [31:0] IDL  = 32'h0000_0000;
    localparam logic [31:0] EOMW = 32'h8000_4000;
    localparam logic [31:0] BADW = 32'h9579_6469;

    always #5 clk = ~clk;

    lvds_rx_deframer u_dut (
        .clk(clk), .reset_n(reset_n), .rx_d(rx_d), .rx_en(rx_en), .clear_err(clear_err),
        .sample_i(sample_i), .sample_q(sample_q), .sample_valid(sample_valid),
        .eom(eom), .locked(locked), .err_cnt(err_cnt)
    );

    lvds_rx_deframer #(.ERR_CNT_W(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .rx_d(rx_d), .rx_en(rx_en), .clear_err(clear_err),
        .sample_i(sample_i_b), .sample_q(sample_q_b), .sample_valid(sample_valid_b),
        .eom(eom_b), .locked(locked_b), .err_cnt(err_cnt_b)
    );

    always @(posedge clk) begin
        #1;
        if (mon_on && sample_valid) begin
            mon_i.push_back(sample_i);
            mon_q.push_back(sample_q);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mk(input logic [12:0] i, input logic [12:0] q);
        return {2'b10, i, 1'b1, 2'b01, q, 1'b0};
    endfunction

    function automatic string fmt(input logic sv, input logic ev, input logic [12:0] i,
                                  input logic [12:0] q, input logic lk,
                                  input logic [7:0] e1, input logic [1:0] e2);
        return $sformatf("sv=%b eom=%b i=%h q=%h lk=%b err=%0d err2=%0d", sv, ev, i, q, lk, e1, e2);
    endfunction

    task automatic check(input string name, input bit ok, input string detail);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic add(input logic [31:0] f, input logic clr, input logic sv, input logic ev,
                       input logic [12:0] ei, input logic [12:0] eq, input logic lk,
                       input logic [7:0] e1, input logic [1:0] e2);
        vec_t v;
        v.frame = f; v.clr = clr; v.sv = sv; v.ev = ev;
        v.ei = ei; v.eq = eq; v.lk = lk; v.e1 = e1; v.e2 = e2;
        vecs.push_back(v);
    endtask

    task automatic send_dibit(input logic [1:0] d);
        rx_en = 1'b1;
        rx_d  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        rx_en = 1'b0;
        rx_d  = 2'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] f);
        for (int k = 0; k < 16; k++) begin
            send_dibit({f[30-2*k], f[31-2*k]});
        end
    endtask

    initial begin
        vec_t        v;
        string       got_s, exp_s;
        bit          ok;
        logic [31:0] d0, word;

        reset_n = 1'b0; rx_en = 1'b0; clear_err = 1'b0; rx_d = 2'b00;

        d0 = mk(13'h0ABC, 13'h1234);
        // acquisition: data frames every fifth frame, lock on the third
        add(d0, 0, 0, 0, 13'h0000, 13'h0000, 0, 8'd0, 2'd0);
        for (int r = 0; r < 4; r++) add(IDL, 0, 0, 0, 13'h0000, 13'h0000, 0, 8'd0, 2'd0);
        add(d0, 0, 0, 0, 13'h0000, 13'h0000, 0, 8'd0, 2'd0);
        for (int r = 0; r < 4; r++) add(IDL, 0, 0, 0, 13'h0000, 13'h0000, 0, 8'd0, 2'd0);
        add(d0, 0, 1, 0, 13'h0ABC, 13'h1234, 1, 8'd0, 2'd0);
        add(IDL, 0, 0, 0, 13'h0ABC, 13'h1234, 1, 8'd0, 2'd0);
        add(EOMW, 0, 0, 1, 13'h0ABC, 13'h1234, 1, 8'd0, 2'd0);
        add(mk(13'h0001, 13'h1FFF), 0, 1, 0, 13'h0001, 13'h1FFF, 1, 8'd0, 2'd0);
        // loss of lock
        for (int r = 1; r <= 3; r++) add(BADW, 0, 0, 0, 13'h0001, 13'h1FFF, 1, 8'(r), 2'(r));
        add(mk(13'h1000, 13'h0FFF), 0, 1, 0, 13'h1000, 13'h0FFF, 1, 8'd3, 2'd3);
        for (int r = 4; r <= 7; r++) add(BADW, 0, 0, 0, 13'h1000, 13'h0FFF, r < 7, 8'(r), 2'd3);
        add(IDL, 1, 0, 0, 13'h1000, 13'h0FFF, 0, 8'd0, 2'd0);
        // relock, then bad frames interleaved with good ones
        add(mk(13'h0111, 13'h0222), 0, 0, 0, 13'h1000, 13'h0FFF, 0, 8'd0, 2'd0);
        add(mk(13'h0333, 13'h0444), 0, 0, 0, 13'h1000, 13'h0FFF, 0, 8'd0, 2'd0);
        add(mk(13'h0555, 13'h0666), 0, 1, 0, 13'h0555, 13'h0666, 1, 8'd0, 2'd0);
        add(BADW, 0, 0, 0, 13'h0555, 13'h0666, 1, 8'd1, 2'd1);
        add(EOMW, 0, 0, 1, 13'h0555, 13'h0666, 1, 8'd1, 2'd1);
        add(BADW, 0, 0, 0, 13'h0555, 13'h0666, 1, 8'd2, 2'd2);
        add(mk(13'h1FFF, 13'h0000), 0, 1, 0, 13'h1FFF, 13'h0000, 1, 8'd2, 2'd2);
        add(BADW, 0, 0, 0, 13'h1FFF, 13'h0000, 1, 8'd3, 2'd3);
        add(EOMW, 0, 0, 1, 13'h1FFF, 13'h0000, 1, 8'd3, 2'd3);
        add(BADW, 0, 0, 0, 13'h1FFF, 13'h0000, 1, 8'd4, 2'd3);
        add(d0, 0, 1, 0, 13'h0ABC, 13'h1234, 1, 8'd4, 2'd3);
        add(BADW, 0, 0, 0, 13'h0ABC, 13'h1234, 1, 8'd5, 2'd3);
        add(EOMW, 0, 0, 1, 13'h0ABC, 13'h1234, 1, 8'd5, 2'd3);
        add(BADW, 0, 0, 0, 13'h0ABC, 13'h1234, 1, 8'd6, 2'd3);
        add(mk(13'h0001, 13'h0002), 0, 1, 0, 13'h0001, 13'h0002, 1, 8'd6, 2'd3);
        add(BADW, 1, 0, 0, 13'h0001, 13'h0002, 1, 8'd0, 2'd0);
        add(IDL, 0, 0, 0, 13'h0001, 13'h0002, 1, 8'd0, 2'd0);

        repeat (3) @(posedge clk);
        #1;
        got_s = fmt(sample_valid, eom, sample_i, sample_q, locked, err_cnt, err_cnt_b);
        check("reset_state", got_s == fmt(0, 0, 13'h0, 13'h0, 0, 8'd0, 2'd0) && !locked_b,
              $sformatf("got %s, expected all zero", got_s));
        reset_n = 1'b1;
        repeat (2) idle_cycle();
        repeat (5) send_dibit(2'b11);

        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            send_frame(v.frame);
            rx_en = 1'b0;
            clear_err = v.clr;
            @(posedge clk);
            #1;
            clear_err = 1'b0;
            got_s = fmt(sample_valid, eom, sample_i, sample_q, locked, err_cnt, err_cnt_b);
            exp_s = fmt(v.sv, v.ev, v.ei, v.eq, v.lk, v.e1, v.e2);
            ok = (got_s == exp_s) && (sample_valid_b === v.sv) && (eom_b === v.ev)
              && (sample_i_b === v.ei) && (sample_q_b === v.eq) && (locked_b === v.lk);
            @(posedge clk);
            #1;
            ok = ok && !sample_valid && !eom && !sample_valid_b && !eom_b;
            check($sformatf("vec%0d", n), ok,
                  $sformatf("got %s (next sv=%b eom=%b), expected %s then pulses low",
                            got_s, sample_valid, eom, exp_s));
        end

        // asynchronous reset in the middle of a frame while locked
        word = mk(13'h0777, 13'h0888);
        for (int k = 0; k < 7; k++) send_dibit({word[30-2*k], word[31-2*k]});
        #2;
        reset_n = 1'b0;
        #1;
        got_s = fmt(sample_valid, eom, sample_i, sample_q, locked, err_cnt, err_cnt_b);
        check("async_reset", got_s == fmt(0, 0, 13'h0, 13'h0, 0, 8'd0, 2'd0)
              && !locked_b && sample_i_b == 13'h0 && sample_q_b == 13'h0,
              $sformatf("got %s, expected all zero", got_s));
        repeat (2) idle_cycle();
        reset_n = 1'b1;
        repeat (4) idle_cycle();
        check("post_reset", !locked && !locked_b && !sample_valid && err_cnt == 8'd0,
              $sformatf("got lk=%b sv=%b err=%0d, expected lk=0 sv=0 err=0",
                        locked, sample_valid, err_cnt));

        // random rx_en gaps through 20 back-to-back data frames
        mon_on = 1'b1;
        for (int f = 0; f < 20; f++) begin
            word = mk(13'(f), 13'h1F00 + 13'(f));
            for (int k = 0; k < 16; k++) begin
                repeat ($urandom_range(0, 2)) idle_cycle();
                send_dibit({word[30-2*k], word[31-2*k]});
            end
        end
        repeat (4) idle_cycle();
        mon_on = 1'b0;
        check("gap_count", mon_i.size() == 18,
              $sformatf("got %0d pulses, expected 18", mon_i.size()));
        for (int k = 0; k < mon_i.size() && k < 18; k++) begin
            check($sformatf("gap_val%0d", k),
                  mon_i[k] == 13'(k + 2) && mon_q[k] == 13'h1F00 + 13'(k + 2),
                  $sformatf("got i=%h q=%h, expected i=%h q=%h", mon_i[k], mon_q[k],
                            13'(k + 2), 13'h1F00 + 13'(k + 2)));
        end
        check("gap_state", locked && locked_b && err_cnt == 8'd0 && err_cnt_b == 2'd0,
              $sformatf("got lk=%b err=%0d err2=%0d, expected lk=1 err=0 err2=0",
                        locked, err_cnt, err_cnt_b));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
